// File: rtl/rr_arb2.sv
// rr_arb2: two-input round-robin arbiter feeding a registered output stage.
// The held word drives the downstream 2:1 mux; sel=1 passes A, sel=0 passes B.
// Under contention the grant alternates, starting with A after reset.
module rr_arb2 #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         a_valid,
  input  logic [W-1:0] a_data,
  output logic         a_ready,
  input  logic         b_valid,
  input  logic [W-1:0] b_data,
  output logic         b_ready,
  output logic         o_valid,
  output logic [W-1:0] o_data,
  input  logic         o_ready,
  output logic         sel,
  output logic         o_last
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t state, state_nxt;

  // Source of the most recent grant: 1 = A, 0 = B (same encoding as sel).
  logic prio_last;
  logic load;
  logic gnt_a;
  logic gnt_b;

  // Grant selection and next-state decode.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path
    // through the block can leave a value unassigned and infer a latch.
    state_nxt = state;
    gnt_a     = 1'b0;
    gnt_b     = 1'b0;
    load      = (state == EMPTY) | o_ready;

    if (load) begin
      if (a_valid && b_valid) begin
        // Contention: serve the source that did not win last time.
        gnt_a = ~prio_last;
        gnt_b = prio_last;
      end else begin
        gnt_a = a_valid;
        gnt_b = b_valid;
      end
    end

    case (state)
      EMPTY: if (gnt_a || gnt_b) state_nxt = FULL;
      FULL:  if (o_ready && !(gnt_a || gnt_b)) state_nxt = EMPTY;
    endcase
  end

  assign a_ready = gnt_a;
  assign b_ready = gnt_b;
  assign o_valid = (state == FULL);

  // Output-stage occupancy register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of evaluation order.
    if (!rst_n) begin
      state <= EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  // Held word, mux select, repeat flag and round-robin pointer; all update
  // only on a grant and otherwise hold, which keeps sel stable under stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_data    <= '0;
      sel       <= 1'b0;
      o_last    <= 1'b0;
      prio_last <= 1'b0;
    end else if (gnt_a || gnt_b) begin
      o_data    <= gnt_a ? a_data : b_data;
      sel       <= gnt_a;
      o_last    <= (gnt_a == prio_last);
      prio_last <= gnt_a;
    end
  end

endmodule

// File: tb/tb_rr_arb2.sv
// tb_rr_arb2: directed and randomized checks of rr_arb2 against a
// transaction-level reference model plus per-source scoreboards.
module tb_rr_arb2;

  localparam int W        = 8;
  localparam int SRC_NONE = 0;
  localparam int SRC_A    = 1;
  localparam int SRC_B    = 2;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         a_valid, b_valid, o_ready;
  logic [W-1:0] a_data, b_data;
  logic         a_ready, b_ready, o_valid, sel, o_last;
  logic [W-1:0] o_data;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model of the output stage in transaction terms.
  bit           m_valid;
  logic [W-1:0] m_data;
  bit           m_sel;
  bit           m_last;
  int           m_prio;

  // Values sampled at the falling edge of the current cycle.
  logic         s_valid, s_sel, s_last, s_ar, s_br, s_av, s_bv, s_or;
  logic [W-1:0] s_data, s_ad, s_bd;

  // Scoreboard state for the random phase.
  logic [W-1:0] qa[$];
  logic [W-1:0] qb[$];
  int           last_g;

  rr_arb2 #(.W(W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .a_valid (a_valid),
    .a_data  (a_data),
    .a_ready (a_ready),
    .b_valid (b_valid),
    .b_data  (b_data),
    .b_ready (b_ready),
    .o_valid (o_valid),
    .o_data  (o_data),
    .o_ready (o_ready),
    .sel     (sel),
    .o_last  (o_last)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_valid = 1'b0;
    m_data  = '0;
    m_sel   = 1'b0;
    m_last  = 1'b0;
    m_prio  = SRC_B;
  endtask

  // One clock: sample and compare at the falling edge, advance the model at
  // the rising edge, return just after it so the caller can drive new inputs.
  task automatic do_cycle();
    int g;
    bit ld;
    @(negedge clk);
    s_valid = o_valid; s_data = o_data; s_sel = sel; s_last = o_last;
    s_ar = a_ready; s_br = b_ready; s_av = a_valid; s_bv = b_valid;
    s_ad = a_data; s_bd = b_data; s_or = o_ready;

    ld = !m_valid || o_ready;
    g  = SRC_NONE;
    if (ld) begin
      if (a_valid && !b_valid)      g = SRC_A;
      else if (b_valid && !a_valid) g = SRC_B;
      else if (a_valid && b_valid)  g = (m_prio == SRC_A) ? SRC_B : SRC_A;
    end

    check("a_ready", a_ready, g == SRC_A);
    check("b_ready", b_ready, g == SRC_B);
    check("ready_onehot", a_ready & b_ready, 0);
    check("o_valid", o_valid, m_valid);
    check("o_data", o_data, m_data);
    check("sel", sel, m_sel);
    check("o_last", o_last, m_last);

    @(posedge clk);
    if (g != SRC_NONE) begin
      m_data  = (g == SRC_A) ? a_data : b_data;
      m_sel   = (g == SRC_A);
      m_last  = (g == m_prio);
      m_prio  = g;
      m_valid = 1'b1;
    end else if (ld) begin
      m_valid = 1'b0;
    end
    #1;
  endtask

  // Scoreboard bookkeeping for the cycle just run by do_cycle().
  task automatic sb_step();
    logic [W-1:0] w;
    if (s_valid && s_or) begin
      if (s_sel) begin
        check("sb_a_nonempty", qa.size() != 0, 1);
        if (qa.size() != 0) begin
          w = qa.pop_front();
          check("sb_a_order", s_data, w);
        end
      end else begin
        check("sb_b_nonempty", qb.size() != 0, 1);
        if (qb.size() != 0) begin
          w = qb.pop_front();
          check("sb_b_order", s_data, w);
        end
      end
    end
    if (s_av && s_bv && (s_ar || s_br))
      check("rr_no_repeat", s_ar ? SRC_A : SRC_B, (last_g == SRC_A) ? SRC_B : SRC_A);
    if (s_ar) begin qa.push_back(s_ad); last_g = SRC_A; end
    if (s_br) begin qb.push_back(s_bd); last_g = SRC_B; end
  endtask

  initial begin
    logic [W-1:0] cseq [4];
    logic         csel [4];
    int na, nb, n;

    cseq[0] = 8'hA0; cseq[1] = 8'hB0; cseq[2] = 8'hA1; cseq[3] = 8'hB1;
    csel[0] = 1'b1;  csel[1] = 1'b0;  csel[2] = 1'b1;  csel[3] = 1'b0;

    // Power-up reset.
    rst_n = 1'b1; a_valid = 0; b_valid = 0; o_ready = 0; a_data = '0; b_data = '0;
    model_reset();
    #2 rst_n = 1'b0;
    #1;
    check("reset_o_valid", o_valid, 0);
    check("reset_o_data", o_data, 0);
    check("reset_sel", sel, 0);
    check("reset_o_last", o_last, 0);
    #4 rst_n = 1'b1;
    @(posedge clk); #1;

    // Fill the output stage, then reset asynchronously mid-cycle while FULL.
    a_valid = 1; a_data = 8'hEE; o_ready = 0;
    do_cycle();
    a_valid = 0;
    do_cycle();
    check("full_before_reset", s_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check("midreset_o_valid", o_valid, 0);
    check("midreset_o_data", o_data, 0);
    check("midreset_sel", sel, 0);
    check("midreset_o_last", o_last, 0);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;

    // Contention with o_ready high: A first, then strict alternation.
    a_valid = 1; b_valid = 1; o_ready = 1; na = 0; nb = 0;
    a_data = 8'hA0; b_data = 8'hB0;
    for (int k = 0; k < 5; k++) begin
      if (k == 4) begin a_valid = 0; b_valid = 0; end
      do_cycle();
      if (k < 4) check("cont_a_ready", s_ar, (k % 2) == 0);
      if (k > 0) begin
        check("cont_data_seq", s_data, cseq[k-1]);
        check("cont_sel_seq", s_sel, csel[k-1]);
        check("cont_o_last", s_last, 0);
      end
      if (s_ar) na++;
      if (s_br) nb++;
      a_data = 8'hA0 + W'(na);
      b_data = 8'hB0 + W'(nb);
    end

    // Single source A: four words back-to-back.
    a_valid = 1; b_valid = 0; n = 0; a_data = 8'h11;
    for (int k = 0; k < 6; k++) begin
      if (n == 4) a_valid = 0;
      do_cycle();
      check("single_b_ready", s_br, 0);
      if (k >= 1 && k <= 4) begin
        check("single_valid", s_valid, 1);
        check("single_data", s_data, 8'h10 + k);
        check("single_sel", s_sel, 1);
        check("single_o_last", s_last, k != 1);
      end
      if (s_ar) begin n++; a_data = 8'h11 + W'(n); end
    end
    check("single_count", n, 4);

    // Backpressure: hold 8'h5A with o_ready low for three cycles.
    a_valid = 1; a_data = 8'h5A; b_valid = 0; o_ready = 1;
    do_cycle();
    a_data = 8'h5B; b_valid = 1; b_data = 8'hC3; o_ready = 0;
    for (int k = 0; k < 3; k++) begin
      do_cycle();
      check("bp_valid", s_valid, 1);
      check("bp_data", s_data, 8'h5A);
      check("bp_sel", s_sel, 1);
      check("bp_ready_none", {s_ar, s_br}, 2'b00);
    end
    o_ready = 1;
    do_cycle();
    check("bp_release_b_taken", s_br, 1);
    b_valid = 0;
    do_cycle();
    check("bp_next_data", s_data, 8'hC3);
    check("bp_next_sel", s_sel, 0);

    // Drain to empty: one word from B, then nothing.
    a_valid = 0; b_valid = 1; b_data = 8'h77;
    do_cycle();
    b_valid = 0;
    do_cycle();
    check("drain_valid_1", s_valid, 1);
    check("drain_data_1", s_data, 8'h77);
    for (int k = 0; k < 2; k++) begin
      do_cycle();
      check("drain_valid_0", s_valid, 0);
      check("drain_data_held", s_data, 8'h77);
    end

    // Random stress with scoreboards; sources honour the hold rule.
    last_g = (m_prio == SRC_A) ? SRC_A : SRC_B;
    s_ar = 0; s_br = 0;
    for (int i = 0; i < 1000; i++) begin
      if (!(a_valid && !s_ar)) begin a_valid = 1'($urandom_range(0, 1)); a_data = W'($urandom); end
      if (!(b_valid && !s_br)) begin b_valid = 1'($urandom_range(0, 1)); b_data = W'($urandom); end
      o_ready = ($urandom_range(0, 3) != 0);
      do_cycle();
      sb_step();
    end
    while (a_valid && !s_ar || b_valid && !s_br) begin
      o_ready = 1;
      if (a_valid && s_ar) a_valid = 0;
      if (b_valid && s_br) b_valid = 0;
      do_cycle();
      sb_step();
      if (n_checks > 90000) break;
    end
    a_valid = 0; b_valid = 0; o_ready = 1;
    for (int k = 0; k < 3; k++) begin
      do_cycle();
      sb_step();
    end
    check("sb_a_drained", qa.size(), 0);
    check("sb_b_drained", qb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
